// File: rtl/mezcladora_pkg.sv
// Shared types and helpers for the mixing-tank controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mezcladora_pkg;

  // Controller states; encoding values are fixed so they are stable in waveforms.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MIX   = 3'd2,
    DRAIN = 3'd3,
    ERROR = 3'd4
  } state_t;

  // Bits needed to index n items, never less than one so a single valve still
  // gets a legal register width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mezcladora_multi_timer.sv
// Shared phase counter with synchronous clear, enable and terminal match.
// Latency: count updates on the clock edge; Match is combinational from the count.
// Backpressure: none; counts whenever enabled.
module mezcla_timer #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             En,
  input  logic [CNT_W-1:0] Cmp,
  output logic             Match
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority over counting so a phase change always restarts at zero.
  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign Match = (cnt == Cmp);

endmodule

// File: rtl/mezcladora_multi.sv
// Mixing-tank sequencer: fill each ingredient, mix for a fixed time, then drain.
// Latency: outputs follow inputs by one clock (all decoded from registered state).
// Backpressure: none; sensor and button inputs are sampled every cycle.
module mezcladora_multi
  import mezcladora_pkg::*;
#(
  parameter int N_ING        = 3,
  parameter int CNT_W        = 8,
  parameter int MIX_TICKS    = 20,
  parameter int FILL_TIMEOUT = 200
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IN,
  input  logic             Abort,
  input  logic             Clr,
  input  logic [N_ING-1:0] P,
  output logic [N_ING-1:0] V,
  output logic             M,
  output logic             D,
  output logic             B,
  output logic             Busy,
  output logic             Err,
  output logic             Done
);

  localparam int               IDX_W    = clog2(N_ING);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ING - 1);
  localparam logic [CNT_W-1:0] CMP_FILL = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMP_MIX  = CNT_W'(MIX_TICKS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             aborted, aborted_n;
  logic             done_n;
  logic             p_nz;
  logic             cnt_clr, cnt_en, cnt_match;
  logic [CNT_W-1:0] cnt_cmp;

  // The single counter times the mix phase or guards fill/drain against a stuck sensor.
  assign cnt_cmp = (state == MIX) ? CMP_MIX : CMP_FILL;

  mezcla_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (cnt_clr),
    .En    (cnt_en),
    .Cmp   (cnt_cmp),
    .Match (cnt_match)
  );

  // State register plus the registered copy of "tank not empty" used by the
  // ERROR-state pump so no sensor reaches an output combinationally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      aborted <= 1'b0;
      Done    <= 1'b0;
      p_nz    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      aborted <= aborted_n;
      Done    <= done_n;
      p_nz    <= |P;
    end
  end

  // Next-state logic; Abort beats timeout, and a sensor hit beats a fill timeout.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    aborted_n = aborted;
    done_n    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (IN) begin
          state_n = FILL;
          idx_n   = '0;
        end
      end
      FILL: begin
        if (Abort) begin
          state_n   = DRAIN;
          cnt_clr   = 1'b1;
          aborted_n = 1'b1;
        end else if (P[idx]) begin
          cnt_clr = 1'b1;
          if (idx == IDX_LAST) state_n = MIX;
          else                 idx_n   = idx + IDX_W'(1);
        end else if (cnt_match) begin
          state_n = ERROR;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      MIX: begin
        if (Abort) begin
          state_n   = DRAIN;
          cnt_clr   = 1'b1;
          aborted_n = 1'b1;
        end else if (cnt_match) begin
          state_n = DRAIN;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        if (P == '0) begin
          state_n   = IDLE;
          cnt_clr   = 1'b1;
          done_n    = ~aborted;
          aborted_n = 1'b0;
        end else if (cnt_match) begin
          state_n = ERROR;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ERROR: begin
        cnt_clr = 1'b1;
        if (Clr && (P == '0)) begin
          state_n   = IDLE;
          aborted_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Output decode from registered state, stage index and registered tank level.
  always_comb begin
    V    = '0;
    M    = 1'b0;
    D    = 1'b0;
    B    = 1'b0;
    Err  = 1'b0;
    Busy = (state != IDLE);
    case (state)
      FILL:  V[idx] = 1'b1;
      MIX:   M = 1'b1;
      DRAIN: begin
        D = 1'b1;
        B = 1'b1;
      end
      ERROR: begin
        Err = 1'b1;
        D   = p_nz;
        B   = p_nz;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mezcladora_multi.sv
// Self-checking bench for the mixing-tank controller.
// Latency: inputs applied before an edge, outputs checked 1 ns after it.
// Backpressure: n/a.
module tb_mezcladora_multi;

  localparam int NI = 3;
  localparam int MT = 4;
  localparam int FT = 10;

  logic          Clk, Reset, IN, Abort, Clr;
  logic [NI-1:0] P, V;
  logic          M, D, B, Busy, Err, Done;

  mezcladora_multi #(.N_ING(NI), .CNT_W(8), .MIX_TICKS(MT), .FILL_TIMEOUT(FT)) dut (
    .Clk(Clk), .Reset(Reset), .IN(IN), .Abort(Abort), .Clr(Clr), .P(P),
    .V(V), .M(M), .D(D), .B(B), .Busy(Busy), .Err(Err), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_MIX = 2, PH_DRAIN = 3, PH_ERR = 4;
  int m_phase   = PH_IDLE;
  int m_stage   = 0;
  int m_spent   = 0;   // cycles already spent in current phase/stage
  bit m_aborted = 0;
  bit m_done    = 0;
  bit m_full    = 0;   // tank level as seen at the last edge

  task automatic model_step(input bit rst, input bit in, input bit ab, input bit clr,
                            input logic [NI-1:0] p);
    bit empty;
    empty  = (p == 0);
    m_done = 0;
    if (rst) begin
      m_phase = PH_IDLE; m_stage = 0; m_spent = 0; m_aborted = 0; m_full = 0;
      return;
    end
    m_full = !empty;
    if (ab && (m_phase == PH_FILL || m_phase == PH_MIX)) begin
      m_phase = PH_DRAIN; m_spent = 0; m_aborted = 1;
      return;
    end
    case (m_phase)
      PH_IDLE: if (in) begin m_phase = PH_FILL; m_stage = 0; m_spent = 0; end
      PH_FILL: begin
        if (p[m_stage]) begin
          m_spent = 0;
          if (m_stage == NI - 1) m_phase = PH_MIX;
          else m_stage++;
        end else if (m_spent + 1 >= FT) m_phase = PH_ERR;
        else m_spent++;
      end
      PH_MIX: begin
        if (m_spent + 1 >= MT) begin m_phase = PH_DRAIN; m_spent = 0; end
        else m_spent++;
      end
      PH_DRAIN: begin
        if (empty) begin
          m_phase = PH_IDLE; m_done = !m_aborted; m_aborted = 0;
        end else if (m_spent + 1 >= FT) m_phase = PH_ERR;
        else m_spent++;
      end
      default: if (clr && empty) begin m_phase = PH_IDLE; m_aborted = 0; end
    endcase
  endtask

  // Expected {V,M,D,B,Busy,Err,Done}
  function automatic logic [8:0] model_out();
    logic [2:0] v;
    logic       pump;
    v    = (m_phase == PH_FILL) ? (3'b001 << m_stage) : 3'b000;
    pump = (m_phase == PH_DRAIN) || (m_phase == PH_ERR && m_full);
    return {v, m_phase == PH_MIX, pump, pump, m_phase != PH_IDLE, m_phase == PH_ERR, m_done};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {V, M, D, B, Busy, Err, Done};
  endfunction

  // ---------------- drive / check helpers ----------------
  task automatic step(input bit rst, input bit in, input bit ab, input bit clr,
                      input logic [NI-1:0] p);
    Reset = rst; IN = in; Abort = ab; Clr = clr; P = p;
    @(posedge Clk);
    model_step(rst, in, ab, clr, p);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got={V,M,D,B,Busy,Err,Done}=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic stepc(input string name, input bit rst, input bit in, input bit ab,
                       input bit clr, input logic [NI-1:0] p);
    step(rst, in, ab, clr, p);
    chk(name, dut_vec(), model_out());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, in, ab, clr;
    logic [2:0] p;
    logic [8:0] exp;
  } vec_t;
  vec_t tab[$];

  task automatic add(input bit rst, input bit in, input bit ab, input bit clr,
                     input logic [2:0] p, input logic [8:0] exp, input int n);
    vec_t r;
    r.rst = rst; r.in = in; r.ab = ab; r.clr = clr; r.p = p; r.exp = exp;
    for (int k = 0; k < n; k++) tab.push_back(r);
  endtask

  initial begin
    Reset = 1; IN = 0; Abort = 0; Clr = 0; P = '0;

    // Normal run: exp = {V,M,D,B,Busy,Err,Done}
    add(1, 0, 0, 0, 3'b000, 9'b000_000000, 1);  // reset
    add(0, 1, 0, 0, 3'b000, 9'b001_000100, 1);  // start -> V0
    add(0, 0, 0, 0, 3'b000, 9'b001_000100, 1);
    add(0, 0, 0, 0, 3'b001, 9'b010_000100, 3);  // P0 -> V1
    add(0, 0, 0, 0, 3'b011, 9'b100_000100, 3);  // P1 -> V2
    add(0, 0, 0, 0, 3'b111, 9'b000_100100, 4);  // mixer exactly 4 cycles
    add(0, 0, 0, 0, 3'b111, 9'b000_011100, 2);  // drain
    add(0, 0, 0, 0, 3'b000, 9'b000_000001, 1);  // empty -> Done pulse, idle
    add(0, 0, 0, 0, 3'b000, 9'b000_000000, 1);
    // Fill timeout then error acknowledge
    add(0, 1, 0, 0, 3'b000, 9'b001_000100, 1);
    add(0, 0, 0, 0, 3'b000, 9'b001_000100, 9);  // 10 cycles of V0 in total
    add(0, 0, 0, 0, 3'b000, 9'b000_000110, 1);  // ERROR, tank empty -> no pump
    add(0, 0, 0, 0, 3'b001, 9'b000_011110, 1);  // liquid seen -> pump on
    add(0, 0, 0, 1, 3'b001, 9'b000_011110, 1);  // Clr ignored while not empty
    add(0, 0, 0, 1, 3'b000, 9'b000_000000, 1);  // Clr with empty tank -> idle
    add(0, 0, 0, 0, 3'b000, 9'b000_000000, 1);

    foreach (tab[i]) begin
      step(tab[i].rst, tab[i].in, tab[i].ab, tab[i].clr, tab[i].p);
      chk($sformatf("tab%0d", i), dut_vec(), tab[i].exp);
    end

    // Abort during second mix cycle
    stepc("a_rst", 1, 0, 0, 0, 3'b000);
    stepc("a_in", 0, 1, 0, 0, 3'b000);
    stepc("a_f0", 0, 0, 0, 0, 3'b001);
    stepc("a_f1", 0, 0, 0, 0, 3'b011);
    stepc("a_f2", 0, 0, 0, 0, 3'b111);
    chk_bit("a_mix1_M", M, 1'b1);
    stepc("a_mix2", 0, 0, 0, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    chk_bit("a_abort_M", M, 1'b0);
    chk_bit("a_abort_B", B, 1'b1);
    chk_bit("a_abort_D", D, 1'b1);
    step(0, 0, 0, 0, 3'b000);
    chk_bit("a_no_done", Done, 1'b0);
    chk_bit("a_idle_busy", Busy, 1'b0);

    // Sensor on the timeout cycle wins; abort beats timeout
    stepc("b_rst", 1, 0, 0, 0, 3'b000);
    stepc("b_in", 0, 1, 0, 0, 3'b000);
    for (int k = 0; k < FT - 1; k++) stepc("b_wait0", 0, 0, 0, 0, 3'b000);
    step(0, 0, 0, 0, 3'b001);
    chk("b_late_p0", dut_vec(), 9'b010_000100);
    for (int k = 0; k < FT - 1; k++) stepc("b_wait1", 0, 0, 0, 0, 3'b001);
    step(0, 0, 1, 0, 3'b001);
    chk("b_abort_to", dut_vec(), 9'b000_011100);
    step(0, 0, 0, 0, 3'b000);
    chk("b_no_done", dut_vec(), 9'b000_000000);

    // Reset in the middle of draining
    stepc("c_rst", 1, 0, 0, 0, 3'b000);
    stepc("c_in", 0, 1, 0, 0, 3'b111);
    for (int k = 0; k < 7; k++) stepc("c_run", 0, 0, 0, 0, 3'b111);
    chk_bit("c_drain_D", D, 1'b1);
    step(1, 1, 0, 0, 3'b111);
    chk("c_reset_out", dut_vec(), 9'b000_000000);
    step(0, 1, 0, 0, 3'b111);
    chk("c_restart", dut_vec(), 9'b001_000100);

    // Start held high across a whole run
    stepc("d_rst", 1, 0, 0, 0, 3'b000);
    stepc("d_in", 0, 1, 0, 0, 3'b111);
    for (int k = 0; k < 7; k++) stepc("d_run", 0, 1, 0, 0, 3'b111);
    chk_bit("d_drain_B", B, 1'b1);
    step(0, 1, 0, 0, 3'b000);
    chk("d_done", dut_vec(), 9'b000_000001);
    step(0, 1, 0, 0, 3'b000);
    chk("d_again", dut_vec(), 9'b001_000100);

    // Randomised traffic against the model
    begin
      logic [2:0] rp;
      rp = 3'b000;
      stepc("r_rst", 1, 0, 0, 0, 3'b000);
      for (int i = 0; i < 4000; i++) begin
        bit rr, ri, ra, rc;
        rr = ($urandom_range(0, 299) == 0);
        ri = ($urandom_range(0, 3) == 0);
        ra = ($urandom_range(0, 39) == 0);
        rc = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       rp = 3'b000;
            1:       rp = 3'b111;
            default: rp = 3'($urandom_range(0, 7));
          endcase
        end
        stepc($sformatf("rnd%0d", i), rr, ri, ra, rc, rp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
